// File: rtl/uart_level_pkg.sv
`default_nettype none
// ============================================================================
// uart_level_pkg : shared FSM state type, packet constants, checksum helper
// Revision 1.0
// ============================================================================
package uart_level_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_SYNC = 2'd1,
    ST_GOT_ADDR = 2'd2,
    ST_GOT_VAL  = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] CHK_SALT     = 8'h5A;

  function automatic logic [7:0] chk(input logic [7:0] addr, input logic [7:0] val);
    return addr ^ val ^ CHK_SALT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/level_bank.sv
`default_nettype none
// ============================================================================
// level_bank : shadow level registers plus display bank loaded on commit
// Revision 1.0
// ============================================================================
module level_bank #(
  parameter int NUM_CH = 8,
  parameter int AW     = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  commit,
  output logic [NUM_CH*8-1:0]   levels
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0] r_shadow;
      logic [7:0] r_disp;

      // Commit samples the pre-write shadow value, so a same-cycle write waits a frame.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_shadow <= '0;
          r_disp   <= '0;
        end else begin
          if (wr_en && (wr_addr == AW'(gi)))
            r_shadow <= wr_data;
          if (commit)
            r_disp <= r_shadow;
        end
      end

      assign levels[gi*8 +: 8] = r_disp;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_level_ctrl.sv
`default_nettype none
// ============================================================================
// uart_level_ctrl : UART packet parser feeding a frame-synchronous level bank
// Revision 1.0
// ============================================================================
module uart_level_ctrl
  import uart_level_pkg::*;
#(
  parameter int         NUM_CH         = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_frame_err,
  input  logic                  frame_start,
  output logic [NUM_CH*8-1:0]   levels,
  output logic                  pkt_ok,
  output logic                  pkt_err,
  output logic [7:0]            err_cnt,
  output logic                  busy
);

  localparam int            AW     = $clog2(NUM_CH);
  localparam int            TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_addr, w_addr_nxt;
  logic [7:0]    r_val, w_val_nxt;
  logic [TW-1:0] r_tcnt, w_tcnt_nxt;
  logic          r_pkt_ok, r_pkt_err;
  logic [7:0]    r_err_cnt;
  logic          w_wr_en, w_ok_evt, w_err_evt, w_addr_ok;

  assign w_addr_ok = ((r_addr >> AW) == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_val     <= '0;
      r_tcnt    <= '0;
      r_pkt_ok  <= 1'b0;
      r_pkt_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_val     <= w_val_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_pkt_ok  <= w_ok_evt;
      r_pkt_err <= w_err_evt;
      if (w_err_evt && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Abort sources (frame error, timeout) only act mid-packet; a frame error beats a byte.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_val_nxt   = r_val;
    w_tcnt_nxt  = r_tcnt;
    w_wr_en     = 1'b0;
    w_ok_evt    = 1'b0;
    w_err_evt   = 1'b0;
    if ((r_state != ST_IDLE) && rx_frame_err) begin
      w_state_nxt = ST_IDLE;
      w_tcnt_nxt  = '0;
      w_err_evt   = 1'b1;
    end else if (rx_valid) begin
      w_tcnt_nxt = '0;
      case (r_state)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE)
            w_state_nxt = ST_GOT_SYNC;
        end
        ST_GOT_SYNC: begin
          w_addr_nxt  = rx_data;
          w_state_nxt = ST_GOT_ADDR;
        end
        ST_GOT_ADDR: begin
          w_val_nxt   = rx_data;
          w_state_nxt = ST_GOT_VAL;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          if ((rx_data == chk(r_addr, r_val)) && w_addr_ok) begin
            w_wr_en  = 1'b1;
            w_ok_evt = 1'b1;
          end else begin
            w_err_evt = 1'b1;
          end
        end
      endcase
    end else if (r_state != ST_IDLE) begin
      if (r_tcnt == TO_MAX) begin
        w_state_nxt = ST_IDLE;
        w_tcnt_nxt  = '0;
        w_err_evt   = 1'b1;
      end else begin
        w_tcnt_nxt = r_tcnt + 1'b1;
      end
    end else begin
      w_tcnt_nxt = '0;
    end
  end

  level_bank #(
    .NUM_CH (NUM_CH),
    .AW     (AW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_addr (r_addr[AW-1:0]),
    .wr_data (r_val),
    .commit  (frame_start),
    .levels  (levels)
  );

  assign pkt_ok  = r_pkt_ok;
  assign pkt_err = r_pkt_err;
  assign err_cnt = r_err_cnt;
  assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_level_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_level_ctrl : directed stimulus, packet-level reference model, literal pins
// Revision 1.0
// ============================================================================
module tb_uart_level_ctrl;

  localparam int NUM_CH = 8;
  localparam int TO     = 100;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                rx_valid = 1'b0;
  logic                rx_frame_err = 1'b0;
  logic                frame_start = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic [NUM_CH*8-1:0] levels;
  logic                pkt_ok, pkt_err, busy;
  logic [7:0]          err_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_level_ctrl #(
    .NUM_CH         (NUM_CH),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .frame_start  (frame_start),
    .levels       (levels),
    .pkt_ok       (pkt_ok),
    .pkt_err      (pkt_err),
    .err_cnt      (err_cnt),
    .busy         (busy)
  );

  // Reference model: bytes collected so far, idle gap, both banks, error total.
  bit         m_started = 0;
  int         m_held = 0;
  int         m_gap = 0;
  int         m_errs = 0;
  bit         m_ok = 0, m_err = 0;
  logic [7:0] m_pkt [4];
  logic [7:0] m_shadow [NUM_CH];
  logic [7:0] m_disp [NUM_CH];

  task automatic model_step();
    logic [7:0] snap [NUM_CH];
    logic [7:0] want;
    if (rst) begin
      m_started = 1;
      m_held = 0; m_gap = 0; m_errs = 0; m_ok = 0; m_err = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] = 8'h00;
        m_disp[i]   = 8'h00;
      end
      return;
    end
    m_ok = 0; m_err = 0;
    snap = m_shadow;
    if (m_held > 0 && rx_frame_err) begin
      m_held = 0; m_gap = 0; m_err = 1;
    end else if (rx_valid) begin
      m_gap = 0;
      if (m_held == 0) begin
        if (rx_data == 8'hA5) m_held = 1;
      end else if (m_held < 3) begin
        m_pkt[m_held] = rx_data;
        m_held++;
      end else begin
        want = m_pkt[1] ^ m_pkt[2] ^ 8'h5A;
        if (rx_data == want && m_pkt[1] < NUM_CH) begin
          m_shadow[m_pkt[1]] = m_pkt[2];
          m_ok = 1;
        end else begin
          m_err = 1;
        end
        m_held = 0;
      end
    end else if (m_held > 0) begin
      m_gap++;
      if (m_gap >= TO) begin
        m_held = 0; m_gap = 0; m_err = 1;
      end
    end
    if (m_err && m_errs < 255) m_errs++;
    if (frame_start) m_disp = snap;
  endtask

  function automatic logic [NUM_CH*8-1:0] m_levels();
    logic [NUM_CH*8-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i*8 +: 8] = m_disp[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      check("levels",  levels,  m_levels());
      check("pkt_ok",  pkt_ok,  m_ok);
      check("pkt_err", pkt_err, m_err);
      check("err_cnt", err_cnt, m_errs[7:0]);
      check("busy",    busy,    (m_held != 0));
    end
  end

  // Inputs are applied 1 time unit after an edge and sampled at the next edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic fe, input logic fs);
    rx_valid = v; rx_data = d; rx_frame_err = fe; frame_start = fs;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_frame_err = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drive(1'b1, a, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0);
    drive(1'b1, c, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    idle(2);
    check("L_reset_levels", levels, 64'h0);
    check("L_reset_errcnt", err_cnt, 8'h00);
    check("L_reset_busy", busy, 1'b0);
    rst = 1'b0;
    idle(2);

    // Non-sync byte in IDLE is silently discarded.
    drive(1'b1, 8'h12, 1'b0, 1'b0);
    check("L_idle_junk_busy", busy, 1'b0);
    check("L_idle_junk_err", pkt_err, 1'b0);

    // Basic update to channel 3.
    send3(8'hA5, 8'h03, 8'h7F);
    check("L_basic_busy", busy, 1'b1);
    drive(1'b1, 8'h26, 1'b0, 1'b0);
    check("L_basic_ok", pkt_ok, 1'b1);
    check("L_basic_not_visible", levels[31:24], 8'h00);
    idle(1);
    check("L_basic_ok_pulse", pkt_ok, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("L_basic_commit", levels[31:24], 8'h7F);

    // Bad checksum.
    send3(8'hA5, 8'h02, 8'h40);
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    check("L_badchk_err", pkt_err, 1'b1);
    check("L_badchk_cnt", err_cnt, 8'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("L_badchk_nowrite", levels[31:16], 16'h7F00);

    // Out-of-range address with a correct checksum.
    send3(8'hA5, 8'h09, 8'h10);
    drive(1'b1, 8'h43, 1'b0, 1'b0);
    check("L_range_err", pkt_err, 1'b1);
    check("L_range_cnt", err_cnt, 8'd2);

    // Timeout after A5,01.
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    idle(TO - 1);
    check("L_to_still_busy", busy, 1'b1);
    idle(1);
    check("L_to_err", pkt_err, 1'b1);
    check("L_to_idle", busy, 1'b0);
    check("L_to_cnt", err_cnt, 8'd3);
    send3(8'hA5, 8'h01, 8'h20);
    drive(1'b1, 8'h7B, 1'b0, 1'b0);
    check("L_to_recover_ok", pkt_ok, 1'b1);

    // Commit coinciding with the accepting CHK byte shows the older shadow value.
    send3(8'hA5, 8'h01, 8'h33);
    drive(1'b1, 8'h68, 1'b0, 1'b1);
    check("L_same_cycle_ok", pkt_ok, 1'b1);
    check("L_same_cycle_old", levels[15:8], 8'h20);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("L_same_cycle_next", levels[15:8], 8'h33);

    // Sync value inside a packet is plain data.
    send3(8'hA5, 8'h01, 8'hA5);
    drive(1'b1, 8'hFE, 1'b0, 1'b0);
    check("L_sync_as_data_ok", pkt_ok, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("L_sync_as_data_lvl", levels[15:8], 8'hA5);

    // Frame error together with a byte in GOT_ADDR.
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 8'h04, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    check("L_fe_err", pkt_err, 1'b1);
    check("L_fe_idle", busy, 1'b0);
    check("L_fe_cnt", err_cnt, 8'd4);
    send3(8'hA5, 8'h04, 8'h55);
    drive(1'b1, 8'h0B, 1'b0, 1'b0);
    check("L_fe_recover_ok", pkt_ok, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("L_fe_idle_ignored", pkt_err, 1'b0);

    // Saturation.
    for (int n = 0; n < 260; n++) begin
      send3(8'hA5, 8'h00, 8'h00);
      drive(1'b1, 8'h00, 1'b0, 1'b0);
    end
    idle(1);
    check("L_sat_cnt", err_cnt, 8'hFF);

    // Reset mid-packet.
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    check("L_rst_levels", levels, 64'h0);
    check("L_rst_busy", busy, 1'b0);
    check("L_rst_cnt", err_cnt, 8'h00);
    check("L_rst_ok", pkt_ok, 1'b0);
    check("L_rst_err", pkt_err, 1'b0);
    rst = 1'b0;
    idle(5);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("L_rst_shadow_clear", levels, 64'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_level_ctrl.md
Name: uart_level_ctrl

Overview:
- Command controller between the UART receiver and the VU-meter/VGA renderer.
- Parses received bytes into 4-byte level-update packets, checks each packet, and writes accepted levels into a shadow register bank.
- Commits the shadow bank to the display-visible bank only on a frame-start pulse, so the renderer never sees a partially updated set of channels.
- Also keeps error and packet statistics for debug.

Parameters:
- NUM_CH, 8, number of level channels (power of two, 2..16).
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT_CYCLES, 2000000, maximum clk cycles between bytes of one packet (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one per received byte.
- rx_frame_err  in  1  one-cycle strobe; the UART saw a bad stop bit.
- frame_start  in  1  one-cycle strobe from the VGA timing block at the vsync edge.
- levels  out  NUM_CH*8  display bank; channel i occupies bits [8i+7:8i].
- pkt_ok  out  1  one-cycle strobe when a packet is accepted.
- pkt_err  out  1  one-cycle strobe when a packet is rejected.
- err_cnt  out  8  saturating count of rejected packets.
- busy  out  1  high while a packet is partly received (any state other than IDLE).

Behaviour:
- Reset state:
  - FSM in IDLE.
  - Shadow bank and levels all 0.
  - pkt_ok, pkt_err, busy = 0; err_cnt = 0; timeout counter = 0.
  - No pending commit.
- Packet format: SYNC, ADDR, VALUE, CHK, where CHK = ADDR ^ VALUE ^ 8'h5A.
  - ADDR is valid only if ADDR < NUM_CH (upper bits zero).
- FSM states: IDLE, GOT_SYNC, GOT_ADDR, GOT_VAL. Transitions happen only on cycles where rx_valid=1, except for timeout and frame errors.
  - IDLE: byte == SYNC_BYTE -> GOT_SYNC. Any other byte is discarded silently (no pkt_err).
  - GOT_SYNC: latch ADDR -> GOT_ADDR.
  - GOT_ADDR: latch VALUE -> GOT_VAL.
  - GOT_VAL: compare the byte with the computed CHK, then -> IDLE.
    - Match and ADDR valid: shadow[ADDR] <= VALUE in that cycle; pkt_ok=1 next cycle.
    - Otherwise: pkt_err=1 next cycle.
- Strobe latency: pkt_ok and pkt_err are registered and rise exactly 1 cycle after the CHK byte's rx_valid. They last 1 cycle and are never both high.
- Resync: a SYNC_BYTE value arriving in GOT_SYNC or GOT_ADDR is data, not a resync. Only timeout or a frame error aborts a packet.
- Timeout:
  - Counter clears on every rx_valid and counts while busy.
  - On reaching TIMEOUT_CYCLES-1 in a non-IDLE state: -> IDLE, pkt_err pulse, err_cnt increments.
  - Timeout never fires in IDLE.
- rx_frame_err in a non-IDLE state: abort -> IDLE with pkt_err.
  - In IDLE: ignored.
  - If rx_valid arrives in the same cycle, rx_frame_err wins and the byte is dropped.
- err_cnt increments on each pkt_err and saturates at 255. Only rst clears it.
- Commit: on frame_start, levels <= shadow as of the start of that cycle.
  - A shadow write in the same cycle is not visible until the next frame_start.
  - The shadow bank is not cleared by a commit.
- Reset mid-packet: the partial packet is lost, no strobes are emitted, and both banks clear.
- Width rules:
  - Timeout counter width is $clog2(TIMEOUT_CYCLES).
  - ADDR index uses the low $clog2(NUM_CH) bits after the range check.

Decomposition:
- Shared package uart_level_pkg:
  - FSM state enum (2 bits).
  - SYNC default and the CHK salt constant 8'h5A.
  - Function chk(addr, val).
- One natural sub-module, level_bank: shadow plus display register arrays, write port, and commit strobe.
- FSM, timeout and statistics stay in uart_level_ctrl.

Test Plan:
- Basic update, NUM_CH=8: send A5,03,7F,26 (03^7F^5A). pkt_ok one cycle after the last rx_valid; levels[31:24] stays 0 until frame_start, then becomes 8'h7F.
- Bad checksum: send A5,02,40,00. pkt_err pulse, err_cnt=1, shadow and levels unchanged after frame_start.
- Out-of-range address: send A5,09,10,43 (09^10^5A, checksum correct). pkt_err, err_cnt increments, no write.
- Timeout, TIMEOUT_CYCLES=100: send A5,01, then idle 100 cycles. FSM returns to IDLE with pkt_err. Next A5,01,20,7B (01^20^5A) is accepted.
- Simultaneous events:
  - frame_start in the same cycle as the accepting CHK byte: levels keeps the old value; the new value appears at the following frame_start.
  - rx_frame_err together with rx_valid in GOT_ADDR: abort and pkt_err.
- Saturation and reset: force 260 bad packets, err_cnt=255. Assert rst mid-packet (after A5,05): all outputs 0, busy=0, no strobes.
